// File: rtl/mux_nx1_pkg.sv
// rtl/mux_nx1_pkg.sv - shared constants and grant helper for mux_nx1_reg
//
// Purpose: mode encodings, default parameters and the rotating-priority
//          one-hot grant function used by rr_arbiter.
// Contents:
//   MODE_FIXED / MODE_RR   encodings of the mux_nx1_reg mode port
//   DEFAULT_N / DEFAULT_W  default channel count and data width
//   MAX_N                  largest channel count rr_grant supports
//   rr_grant()             one-hot grant from request vector and start pointer
package mux_nx1_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_W = 8;

  localparam int MAX_N  = 32;
  localparam int MAX_NW = $clog2(MAX_N);

  // Scans n requesters starting at 'start' (start < n), wrapping at n, and
  // returns a one-hot vector for the first one found (all zero if none).
  function automatic logic [MAX_N-1:0] rr_grant(input logic [MAX_N-1:0] req,
                                                input int start,
                                                input int n);
    logic [MAX_N-1:0] grant;
    logic             found;
    int               idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        idx = start + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[MAX_NW-1:0]]) begin
          grant[idx[MAX_NW-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin request arbiter with rotating pointer
//
// Purpose: grants the first requesting channel at or after ptr (wrapping),
//          and moves ptr to one past the channel that completed a transfer.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset (ptr -> 0)
//   req      in   N  per-channel requests
//   advance  in   1  a round-robin transfer happened this cycle
//   adv_ch   in   SELW channel that transferred
//   grant    out  N  one-hot grant (combinational)
module rr_arbiter
  import mux_nx1_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  input  logic [SELW-1:0] adv_ch,
  output logic [N-1:0]    grant
);

  logic [SELW-1:0]  ptr;
  logic [MAX_N-1:0] grant_full;
  logic             unused_grant_bits;

  assign grant_full = rr_grant(MAX_N'(req), int'(ptr), N);
  assign grant      = grant_full[N-1:0];
  // Bits above N are always zero; folded here only so they are consumed.
  assign unused_grant_bits = ^grant_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (adv_ch == SELW'(N - 1)) ? '0 : adv_ch + 1'b1;
    end
  end

endmodule

// File: rtl/mux_nx1_reg.sv
// rtl/mux_nx1_reg.sv - N-to-1 registered mux with valid/ready and optional round-robin
//
// Purpose: selects one of N producer channels (fixed via sel, or round-robin
//          when built with MUX_NX1_RR_EN) into a single-entry output register.
// Config macro: MUX_NX1_RR_EN - compiles in rr_arbiter; without it mode is
//               ignored and the block always uses fixed select.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   mode       in   1     0 = fixed select, 1 = round-robin
//   sel        in   SELW  channel index for fixed mode (>= N grants nothing)
//   in_data    in   N*W   channel i at [i*W +: W]
//   in_valid   in   N     per-channel valid
//   in_ready   out  N     per-channel ready (combinational, 0 in reset)
//   out_data   out  W     registered data
//   out_valid  out  1     output register holds a word
//   out_ready  in   1     consumer accepts the word
//   out_ch     out  SELW  source channel of out_data
module mux_nx1_reg
  import mux_nx1_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_ch
);

  logic [N-1:0]    grant_fixed;
  logic [N-1:0]    grant;
  logic            load_en;
  logic            xfer;
  logic [SELW-1:0] xfer_ch;
  logic [W-1:0]    xfer_data;

  // Compare against every legal index so an out-of-range sel simply matches none.
  always_comb begin
    grant_fixed = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) grant_fixed[i] = in_valid[i];
    end
  end

`ifdef MUX_NX1_RR_EN
  logic [N-1:0] grant_rr;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (xfer && (mode == MODE_RR)),
    .adv_ch  (xfer_ch),
    .grant   (grant_rr)
  );

  assign grant = (mode == MODE_RR) ? grant_rr : grant_fixed;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign grant       = grant_fixed;
`endif

  assign load_en  = !out_valid || out_ready;
  assign in_ready = rst_n ? (grant & {N{load_en}}) : '0;
  assign xfer     = |(in_valid & in_ready);

  // grant is one-hot, so an OR of masked channels is the data mux.
  always_comb begin
    xfer_ch   = '0;
    xfer_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        xfer_ch   = SELW'(i);
        xfer_data = xfer_data | in_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= xfer_data;
      out_ch    <= xfer_ch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
